// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: three one-entry holding registers (ALU, MUL, LD) feed one broadcast per cycle.
// Latency 2 cycles accept->cdb_valid; a source is held off only while its slot is full and not granted.
module cdb_arbiter #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_changeFlow,
    input  logic [DATA_W-1:0] alu_jb_addr,

    input  logic              mul_valid,
    output logic              mul_ready,
    input  logic [TAG_W-1:0]  mul_tag,
    input  logic [DATA_W-1:0] mul_result,

    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [TAG_W-1:0]  ld_tag,
    input  logic [DATA_W-1:0] ld_data,

    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_changeFlow,
    output logic [DATA_W-1:0] cdb_jb_addr,
    output logic [1:0]        cdb_src
);

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MUL = 2'd1;
    localparam logic [1:0] SRC_LD  = 2'd2;

    logic [2:0]        r_hold_v;
    logic [TAG_W-1:0]  r_alu_tag;
    logic [DATA_W-1:0] r_alu_data;
    logic              r_alu_cf;
    logic [DATA_W-1:0] r_alu_jb;
    logic [TAG_W-1:0]  r_mul_tag;
    logic [DATA_W-1:0] r_mul_data;
    logic [TAG_W-1:0]  r_ld_tag;
    logic [DATA_W-1:0] r_ld_data;
    logic [1:0]        r_rr_ptr;

    logic [1:0]        w_p1;
    logic [1:0]        w_p2;
    logic              w_any;
    logic [1:0]        w_gnt_idx;
    logic [2:0]        w_grant;
    logic              w_alu_acc;
    logic              w_mul_acc;
    logic              w_ld_acc;
    logic [TAG_W-1:0]  w_sel_tag;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_cf;
    logic [DATA_W-1:0] w_sel_jb;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Search order after the last winner: rr+1, rr+2, then rr itself.
    always_comb begin
        w_p1      = inc3(r_rr_ptr);
        w_p2      = inc3(w_p1);
        w_any     = 1'b0;
        w_gnt_idx = r_rr_ptr;
        if (r_hold_v[w_p1]) begin
            w_any     = 1'b1;
            w_gnt_idx = w_p1;
        end else if (r_hold_v[w_p2]) begin
            w_any     = 1'b1;
            w_gnt_idx = w_p2;
        end else if (r_hold_v[r_rr_ptr]) begin
            w_any     = 1'b1;
            w_gnt_idx = r_rr_ptr;
        end
        w_grant = '0;
        if (w_any) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    // Ready depends only on slot state and grant, so a granted slot can refill on the same edge.
    assign alu_ready = ~flush & (~r_hold_v[SRC_ALU] | w_grant[SRC_ALU]);
    assign mul_ready = ~flush & (~r_hold_v[SRC_MUL] | w_grant[SRC_MUL]);
    assign ld_ready  = ~flush & (~r_hold_v[SRC_LD]  | w_grant[SRC_LD]);

    assign w_alu_acc = alu_valid & alu_ready;
    assign w_mul_acc = mul_valid & mul_ready;
    assign w_ld_acc  = ld_valid  & ld_ready;

    always_comb begin
        w_sel_tag  = r_alu_tag;
        w_sel_data = r_alu_data;
        w_sel_cf   = r_alu_cf;
        w_sel_jb   = r_alu_jb;
        case (w_gnt_idx)
            SRC_MUL: begin
                w_sel_tag  = r_mul_tag;
                w_sel_data = r_mul_data;
                w_sel_cf   = 1'b0;
                w_sel_jb   = '0;
            end
            SRC_LD: begin
                w_sel_tag  = r_ld_tag;
                w_sel_data = r_ld_data;
                w_sel_cf   = 1'b0;
                w_sel_jb   = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_v   <= '0;
            r_rr_ptr   <= SRC_LD;
            r_alu_tag  <= '0;
            r_alu_data <= '0;
            r_alu_cf   <= 1'b0;
            r_alu_jb   <= '0;
            r_mul_tag  <= '0;
            r_mul_data <= '0;
            r_ld_tag   <= '0;
            r_ld_data  <= '0;
        end else if (flush) begin
            r_hold_v <= '0;
        end else begin
            if (w_any) begin
                r_rr_ptr <= w_gnt_idx;
            end
            if (w_alu_acc) begin
                r_hold_v[SRC_ALU] <= 1'b1;
                r_alu_tag         <= alu_tag;
                r_alu_data        <= alu_result;
                r_alu_cf          <= alu_changeFlow;
                r_alu_jb          <= alu_jb_addr;
            end else if (w_grant[SRC_ALU]) begin
                r_hold_v[SRC_ALU] <= 1'b0;
            end
            if (w_mul_acc) begin
                r_hold_v[SRC_MUL] <= 1'b1;
                r_mul_tag         <= mul_tag;
                r_mul_data        <= mul_result;
            end else if (w_grant[SRC_MUL]) begin
                r_hold_v[SRC_MUL] <= 1'b0;
            end
            if (w_ld_acc) begin
                r_hold_v[SRC_LD] <= 1'b1;
                r_ld_tag         <= ld_tag;
                r_ld_data        <= ld_data;
            end else if (w_grant[SRC_LD]) begin
                r_hold_v[SRC_LD] <= 1'b0;
            end
        end
    end

    // Broadcast registers: one-cycle valid pulse, payload held between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid      <= 1'b0;
            cdb_tag        <= '0;
            cdb_data       <= '0;
            cdb_changeFlow <= 1'b0;
            cdb_jb_addr    <= '0;
            cdb_src        <= SRC_ALU;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= w_any;
            if (w_any) begin
                cdb_tag        <= w_sel_tag;
                cdb_data       <= w_sel_data;
                cdb_changeFlow <= w_sel_cf;
                cdb_jb_addr    <= w_sel_jb;
                cdb_src        <= w_gnt_idx;
            end
        end
    end

endmodule
